// File: rtl/win_trig_counter_pkg.sv
// Shared definitions for the pre/post-trigger window counter.
// Holds the capture FSM state encoding. The encoding is visible on the
// STATE debug port, so the numeric codes are fixed.
package win_trig_counter_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/win_trig_counter_limit_cnt.sv
// Window limit counter: counts qualified samples up to a programmable limit.
// Ports:
//   clk    in  1      clock
//   rst    in  1      asynchronous active-high reset
//   clr    in  1      synchronous clear, has priority over inc
//   inc    in  1      count enable
//   limit  in  CNT_W  target count
//   cnt    out CNT_W  current count
//   hit    out 1      cnt == limit (combinational)
module win_trig_counter_limit_cnt #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The owner stops incrementing once hit is seen, so cnt never passes limit.
  assign hit = (cnt == limit);

endmodule

// File: rtl/win_trig_counter.sv
// Pre/post-trigger window counter for the sample-capture path.
// Produces circular sample-memory write addresses and strobes, guarantees
// PRE_DATA samples before a trigger can be accepted, then captures exactly
// POST_DATA samples after the trigger sample and raises WRITE_READY.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   START             level: 0 clears synchronously to IDLE, 1 runs
//   CLK_EN, EVENT_IN  sample tick qualifiers (EVENT_IN only if EVENT_GATED)
//   TRIG_IN           trigger condition
//   FORCE_TRIG        single-cycle forced trigger request
//   PRE_DATA          pre-trigger sample count
//   POST_DATA         post-trigger sample count
//   SAMPLE_WE         write strobe for the sample memory
//   WR_ADDR           address written when SAMPLE_WE=1 (wraps mod 2**ADDR_W)
//   TRIG_ADDR         address of the trigger sample
//   PRE_FULL          pre-trigger quota satisfied
//   TRIGGERED         trigger accepted
//   WRITE_READY       capture complete
//   STATE             FSM state (debug)
module win_trig_counter
  import win_trig_counter_pkg::*;
#(
  parameter int CNT_W       = 18,
  parameter int ADDR_W      = 10,
  parameter bit EVENT_GATED = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              CLK_EN,
  input  logic              EVENT_IN,
  input  logic              TRIG_IN,
  input  logic              FORCE_TRIG,
  input  logic [CNT_W-1:0]  PRE_DATA,
  input  logic [CNT_W-1:0]  POST_DATA,
  output logic              SAMPLE_WE,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [ADDR_W-1:0] TRIG_ADDR,
  output logic              PRE_FULL,
  output logic              TRIGGERED,
  output logic              WRITE_READY,
  output logic [ST_W-1:0]   STATE
);

  state_t           state;
  logic             force_pend;
  logic             tick;
  logic             accept;
  logic             pre_hit;
  logic             post_hit;
  logic [CNT_W-1:0] pre_cnt;
  logic [CNT_W-1:0] post_cnt;

  assign tick = CLK_EN & (EVENT_GATED ? EVENT_IN : 1'b1);

  // The limit edges in PRE and POST are state changes only; no sample is
  // written on them. This is what makes PRE_DATA=0 / POST_DATA=0 write nothing.
  assign SAMPLE_WE = START & tick &
                     (((state == ST_PRE)  & ~pre_hit)  |
                       (state == ST_WAIT)              |
                      ((state == ST_POST) & ~post_hit));

  assign accept = START & tick & (state == ST_WAIT) & (TRIG_IN | force_pend);

  win_trig_counter_limit_cnt #(.CNT_W(CNT_W)) u_pre_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (~START | (state == ST_IDLE)),
    .inc   (SAMPLE_WE & (state == ST_PRE)),
    .limit (PRE_DATA),
    .cnt   (pre_cnt),
    .hit   (pre_hit)
  );

  // Cleared on trigger acceptance so POST starts counting from zero.
  win_trig_counter_limit_cnt #(.CNT_W(CNT_W)) u_post_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (~START | accept),
    .inc   (SAMPLE_WE & (state == ST_POST)),
    .limit (POST_DATA),
    .cnt   (post_cnt),
    .hit   (post_hit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      force_pend  <= 1'b0;
      WR_ADDR     <= '0;
      TRIG_ADDR   <= '0;
      PRE_FULL    <= 1'b0;
      TRIGGERED   <= 1'b0;
      WRITE_READY <= 1'b0;
    end else if (!START) begin
      state       <= ST_IDLE;
      force_pend  <= 1'b0;
      WR_ADDR     <= '0;
      TRIG_ADDR   <= '0;
      PRE_FULL    <= 1'b0;
      TRIGGERED   <= 1'b0;
      WRITE_READY <= 1'b0;
    end else begin
      if (SAMPLE_WE) begin
        WR_ADDR <= WR_ADDR + ADDR_W'(1);
      end
      case (state)
        ST_IDLE: state <= ST_PRE;
        ST_PRE: begin
          if (FORCE_TRIG) begin
            force_pend <= 1'b1;
          end
          // Limit compare is not tick-gated: leave PRE as soon as the quota is met.
          if (pre_hit) begin
            state    <= ST_WAIT;
            PRE_FULL <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (accept) begin
            // WR_ADDR here is the address the trigger sample is written to.
            TRIG_ADDR  <= WR_ADDR;
            TRIGGERED  <= 1'b1;
            force_pend <= 1'b0;
            state      <= ST_POST;
          end else if (FORCE_TRIG) begin
            force_pend <= 1'b1;
          end
        end
        ST_POST: begin
          if (post_hit) begin
            state       <= ST_DONE;
            WRITE_READY <= 1'b1;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: begin
          state       <= ST_IDLE;
          force_pend  <= 1'b0;
          PRE_FULL    <= 1'b0;
          TRIGGERED   <= 1'b0;
          WRITE_READY <= 1'b0;
        end
      endcase
    end
  end

  assign STATE = state;

endmodule
